// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: accepts one AXI-Stream frame of digit codes
// and scans it out, holding each frame for HOLD_FRAMES full refresh periods.
module seg7_scan_driver #(
   parameter int SEG_W       = 7,
   parameter int N_DIGITS    = 2,
   parameter int PRESCALE    = 4,
   parameter int HOLD_FRAMES = 2,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic [N_DIGITS-1:0][SEG_W-1:0]     s_data,
   output logic [SEG_W-1:0]                   seg_out,
   output logic [N_DIGITS-1:0]                dig_en,
   output logic                               frame_shown
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int HW = $clog2(HOLD_FRAMES + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [DW-1:0] DIG_LAST   = DW'(N_DIGITS - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHOW  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;

   localparam logic [SEG_W-1:0]    SEG_OFF = {SEG_W{ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{ACTIVE_LOW}};

   logic [1:0]                     state_q, state_d;
   logic [PW-1:0]                  presc_q, presc_d;
   logic [DW-1:0]                  dig_q, dig_d;
   logic [HW-1:0]                  hold_q, hold_d;
   logic [N_DIGITS-1:0][SEG_W-1:0] frame_q;
   logic [SEG_W-1:0]               seg_q, seg_d;
   logic [N_DIGITS-1:0]            en_q, en_d;
   logic                           shown_q, shown_d;
   logic                           xfer;

   assign s_ready     = !rst && ((state_q == ST_IDLE) || (state_q == ST_READY));
   assign xfer        = s_valid && s_ready;
   assign seg_out     = seg_q;
   assign dig_en      = en_q;
   assign frame_shown = shown_q;

   // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      dig_d   = dig_q;
      hold_d  = hold_q;
      shown_d = 1'b0;

      if (xfer) begin
         state_d = ST_SHOW;
         presc_d = '0;
         dig_d   = '0;
         hold_d  = '0;
      end else if (state_q != ST_IDLE) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (dig_q == DIG_LAST) begin
               // End of one scan period; only SHOW counts towards the hold.
               dig_d = '0;
               if (state_q == ST_SHOW) begin
                  hold_d = hold_q + 1'b1;
                  if (hold_q == HOLD_LAST) begin
                     state_d = ST_READY;
                     shown_d = 1'b1;
                  end
               end
            end else begin
               dig_d = dig_q + 1'b1;
            end
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end

      if (state_q == ST_IDLE) begin
         seg_d = SEG_OFF;
         en_d  = DIG_OFF;
      end else begin
         seg_d = frame_q[dig_q] ^ SEG_OFF;
         en_d  = (N_DIGITS'(1) << dig_q) ^ DIG_OFF;
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         dig_q   <= '0;
         hold_q  <= '0;
         seg_q   <= SEG_OFF;
         en_q    <= DIG_OFF;
         shown_q <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         dig_q   <= dig_d;
         hold_q  <= hold_d;
         seg_q   <= seg_d;
         en_q    <= en_d;
         shown_q <= shown_d;
      end
   end

   // NOTE: the frame register needs no reset; it is only read outside IDLE, after a load.
   always_ff @(posedge clk) begin
      if (xfer) begin
         frame_q <= s_data;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a default instance and a PRESCALE=1,
// HOLD_FRAMES=1, active-high instance share one stimulus stream.
module tb_seg7_scan_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst = 1'b1;
   logic             s_valid = 1'b0;
   logic [1:0][6:0]  s_data = '0;

   logic       rdy_a, fs_a, rdy_b, fs_b;
   logic [6:0] seg_a, seg_b;
   logic [1:0] dig_a, dig_b;

   seg7_scan_driver dut_a (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy_a), .s_data(s_data),
      .seg_out(seg_a), .dig_en(dig_a), .frame_shown(fs_a)
   );

   seg7_scan_driver #(.PRESCALE(1), .HOLD_FRAMES(1), .ACTIVE_LOW(1'b0)) dut_b (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy_b), .s_data(s_data),
      .seg_out(seg_b), .dig_en(dig_b), .frame_shown(fs_b)
   );

   typedef struct {
      int          phase;   // 0 idle, 1 show, 2 ready
      int          t;       // edges since last transfer
      logic [13:0] frame;
   } mdl_t;

   typedef struct packed {
      logic [6:0] seg;
      logic [1:0] dig;
      logic       fs;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   mdl_t ma = '{0, 0, '0};
   mdl_t mb = '{0, 0, '0};
   int   total = 0;
   int   bad = 0;
   bit   last_xa;
   logic last_rdy_a;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Outputs expected just after the coming edge, from the state before it.
   function automatic exp_t predict(mdl_t m, bit r, bit x, int p, int h, bit al);
      exp_t       e;
      int         d;
      logic [6:0] sg;
      logic [1:0] oh;
      sg = '0;
      oh = '0;
      if (!r && m.phase != 0) begin
         d  = (m.t / p) % 2;
         oh = 2'b01 << d;
         sg = m.frame[d*7 +: 7];
      end
      e.seg = al ? ~sg : sg;
      e.dig = al ? ~oh : oh;
      e.fs  = !r && !x && (m.phase == 1) && (m.t + 1 == h * 2 * p);
      return e;
   endfunction

   function automatic mdl_t advance(mdl_t m, bit r, bit x, logic [13:0] d, int p, int h);
      mdl_t n;
      n = m;
      if (r) begin
         n.phase = 0;
         n.t     = 0;
      end else if (x) begin
         n.phase = 1;
         n.t     = 0;
         n.frame = d;
      end else if (m.phase != 0) begin
         n.t = m.t + 1;
         if (m.phase == 1 && n.t == h * 2 * p) n.phase = 2;
      end
      return n;
   endfunction

   task automatic cyc(input bit r, input bit v, input logic [13:0] d);
      bit   xa, xb;
      exp_t e;
      rst     = r;
      s_valid = v;
      s_data  = d;
      #1;
      check("ready_a", rdy_a, !r && ma.phase != 1);
      check("ready_b", rdy_b, !r && mb.phase != 1);
      last_rdy_a = rdy_a;
      xa = v && !r && ma.phase != 1;
      xb = v && !r && mb.phase != 1;
      last_xa = xa;
      q_a.push_back(predict(ma, r, xa, 4, 2, 1'b1));
      q_b.push_back(predict(mb, r, xb, 1, 1, 1'b0));
      ma = advance(ma, r, xa, d, 4, 2);
      mb = advance(mb, r, xb, d, 1, 1);
      @(posedge clk);
      #1;
      e = q_a.pop_front();
      check("seg_a", seg_a, e.seg);
      check("dig_a", dig_a, e.dig);
      check("shown_a", fs_a, e.fs);
      e = q_b.pop_front();
      check("seg_b", seg_b, e.seg);
      check("dig_b", dig_b, e.dig);
      check("shown_b", fs_b, e.fs);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, s_data);
   endtask

   localparam logic [13:0] F12 = {7'b0000110, 7'b1011011};
   localparam logic [13:0] F34 = {7'b1100110, 7'b1001111};

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int stalls;
      bit done;
      #1;
      // Reset, then idle with blank outputs.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0);
      idle(6);
      check("idle_seg_a", seg_a, 7'h7F);
      check("idle_dig_a", dig_a, 2'b11);

      // Single frame "12", then let it run through hold and a few READY periods.
      cyc(1'b0, 1'b1, F12);
      idle(30);

      // Back-pressure: "12" then "34" held valid until accepted.
      cyc(1'b1, 1'b0, '0);
      cyc(1'b0, 1'b1, F12);
      stalls = 0;
      done   = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         cyc(1'b0, 1'b1, F34);
         if (!last_rdy_a) stalls++;
         if (last_xa) done = 1'b1;
      end
      check("bp_accepted", done, 1'b1);
      check("bp_stalls", stalls, 16);

      // Swap in READY at every offset of a scan period, including the wrap edge.
      for (int off = 0; off < 8; off++) begin
         idle(17);
         idle(off);
         cyc(1'b0, 1'b1, {7'(off * 9), 7'(7'h7F - off)});
         idle(1);
      end
      idle(20);

      // Reset mid-SHOW, seven edges after the transfer.
      cyc(1'b0, 1'b1, {7'h00, 7'h55});
      idle(6);
      cyc(1'b1, 1'b0, s_data);
      idle(20);

      // A few random frames including unusual codes.
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 14'($urandom));
         idle(18 + (i * 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
